// File: rtl/pcs_pkg.sv
// Shared PCS definitions: sync header codes, scrambler polynomial taps, state type.
// Used by the TX scrambler and the RX descrambler.
package pcs_pkg;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

  // x^58 + x^39 + 1 : taps are zero-based positions in the 58-bit history
  localparam int SCR_TAP_A   = 38;
  localparam int SCR_TAP_B   = 57;
  localparam int SCR_STATE_W = 58;

  typedef logic [SCR_STATE_W-1:0] scr_state_t;

  typedef enum logic {
    PHASE_FIRST  = 1'b0,
    PHASE_SECOND = 1'b1
  } blk_phase_t;

endpackage

// File: rtl/scrambler_core.sv
// Combinational self-synchronous x^58+x^39+1 scrambler over one word, bit 0 first.
// DESCRAMBLE=1 feeds the received bit back instead of the output bit (RX use).
module scrambler_core
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit DESCRAMBLE = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  scr_state_t            i_state,
  output logic [DATA_WIDTH-1:0] o_data,
  output scr_state_t            o_state
);

  scr_state_t s;
  logic       fb;

  always_comb begin
    s      = i_state;
    o_data = '0;
    fb     = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      o_data[i] = i_data[i] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
      fb        = DESCRAMBLE ? i_data[i] : o_data[i];
      s         = {s[SCR_STATE_W-2:0], fb};
    end
    o_state = s;
  end

endmodule

// File: rtl/tx_scrambler_64b66b.sv
// 64b/66b TX scrambler stage ahead of the gearbox: scrambles payload, passes header.
// Optional TX_SCRAMBLER_BYPASS_EN adds i_scr_bypass for test-pattern/loopback debug.
module tx_scrambler_64b66b
  import pcs_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter scr_state_t SCR_SEED   = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic [1:0]            i_hdr,
  input  logic                  i_gearbox_pause,
`ifdef TX_SCRAMBLER_BYPASS_EN
  input  logic                  i_scr_bypass,
`endif
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic [1:0]            o_hdr,
  output logic                  o_encoder_pause
);

  // Handshake: a word is accepted when i_data_valid=1 and i_gearbox_pause=0;
  // the encoder holds i_data/i_hdr stable while o_encoder_pause=1.
  logic                  accept;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] scr_data;
  scr_state_t            scr_state_next;

  scr_state_t            scr_state_q, scr_state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [1:0]            hdr_q, hdr_d;
  logic [1:0]            hdr_hold_q, hdr_hold_d;
  blk_phase_t            phase_q, phase_d;

`ifdef TX_SCRAMBLER_BYPASS_EN
  assign bypass = i_scr_bypass;
`else
  assign bypass = 1'b0;
`endif

  assign accept          = i_data_valid & ~i_gearbox_pause;
  assign o_encoder_pause = i_gearbox_pause;

  scrambler_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DESCRAMBLE (1'b0)
  ) u_core (
    .i_data  (i_data),
    .i_state (scr_state_q),
    .o_data  (scr_data),
    .o_state (scr_state_next)
  );

  always_comb begin
    scr_state_d = scr_state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    hdr_d       = hdr_q;
    hdr_hold_d  = hdr_hold_q;
    phase_d     = phase_q;
    // A paused cycle freezes everything, including valid, so nothing is lost
    if (!i_gearbox_pause) begin
      valid_d = i_data_valid;
    end
    if (accept) begin
      data_d      = bypass ? i_data : scr_data;
      scr_state_d = bypass ? scr_state_q : scr_state_next;
      if (phase_q == PHASE_FIRST) begin
        hdr_d      = i_hdr;
        hdr_hold_d = i_hdr;
        phase_d    = PHASE_SECOND;
      end else begin
        hdr_d      = hdr_hold_q;
        phase_d    = PHASE_FIRST;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      scr_state_q <= SCR_SEED;
      data_q      <= '0;
      valid_q     <= 1'b0;
      hdr_q       <= 2'b00;
      hdr_hold_q  <= 2'b00;
      phase_q     <= PHASE_FIRST;
    end else begin
      scr_state_q <= scr_state_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      hdr_q       <= hdr_d;
      hdr_hold_q  <= hdr_hold_d;
      phase_q     <= phase_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_hdr        = hdr_q;

endmodule

// File: tb/tb_tx_scrambler_64b66b.sv
// Bench for tx_scrambler_64b66b: directed vector table, pause/reset/bypass sequences,
// and a random round trip checked through a reference descrambler.
module tb_tx_scrambler_64b66b;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  logic        i_clk;
  logic        i_reset_n;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic [1:0]  i_hdr;
  logic        i_gearbox_pause;
  logic        i_scr_bypass;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic [1:0]  o_hdr;
  logic        o_encoder_pause;

  tx_scrambler_64b66b dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_data          (i_data),
    .i_data_valid    (i_data_valid),
    .i_hdr           (i_hdr),
    .i_gearbox_pause (i_gearbox_pause),
`ifdef TX_SCRAMBLER_BYPASS_EN
    .i_scr_bypass    (i_scr_bypass),
`endif
    .o_data          (o_data),
    .o_data_valid    (o_data_valid),
    .o_hdr           (o_hdr),
    .o_encoder_pause (o_encoder_pause)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [34:0] exp_q[$];        // {bypass, block header, original payload}
  logic [57:0] rx_state = SEED;
  logic        tb_phase = 1'b0;
  logic [1:0]  blk_hdr  = 2'b00;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] descramble(input logic [31:0] r);
    logic [31:0] d;
    for (int i = 0; i < 32; i++) begin
      d[i]     = r[i] ^ rx_state[38] ^ rx_state[57];
      rx_state = {rx_state[56:0], r[i]};
    end
    return d;
  endfunction

  task automatic do_reset(input int cycles, input logic hold_valid);
    i_reset_n       = 1'b0;
    i_data_valid    = hold_valid;
    i_gearbox_pause = 1'b0;
    repeat (cycles) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    rx_state  = SEED;
    tb_phase  = 1'b0;
    exp_q.delete();
  endtask

  // driver + scoreboard: drive one cycle, then compare the DUT output after the edge
  task automatic step(input logic v, input logic p, input logic [1:0] h,
                      input logic [31:0] d, input logic byp);
    logic [34:0] snap;
    logic [34:0] item;
    i_data_valid    = v;
    i_gearbox_pause = p;
    i_hdr           = h;
    i_data          = d;
    i_scr_bypass    = byp;
    #1;
    check("enc_pause", {63'd0, o_encoder_pause}, {63'd0, p});
    if (v && !p) begin
      if (!tb_phase) blk_hdr = h;
      exp_q.push_back({byp, blk_hdr, d});
      tb_phase = ~tb_phase;
    end
    snap = {o_data_valid, o_hdr, o_data};
    @(posedge i_clk);
    #1;
    if (p) begin
      check("pause_hold", {29'd0, o_data_valid, o_hdr, o_data}, {29'd0, snap});
    end else if (!v) begin
      check("idle_valid", {63'd0, o_data_valid}, 64'd0);
    end else begin
      check("out_valid", {63'd0, o_data_valid}, 64'd1);
      if (exp_q.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        item = exp_q.pop_front();
        check("out_hdr", {62'd0, o_hdr}, {62'd0, item[33:32]});
        if (item[34]) check("byp_data", {32'd0, o_data}, {32'd0, item[31:0]});
        else          check("rt_data", {32'd0, descramble(o_data)}, {32'd0, item[31:0]});
      end
    end
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  h;
    logic [31:0] d;
    logic [31:0] mask;
    logic [31:0] exp_data;
    logic [1:0]  exp_hdr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [1:0]  bh;
    logic [31:0] w;
    i_reset_n       = 1'b1;
    i_data          = '0;
    i_data_valid    = 1'b0;
    i_hdr           = 2'b00;
    i_gearbox_pause = 1'b0;
    i_scr_bypass    = 1'b0;

    // seed check, header alignment, idle, illegal headers
    vecs[0] = '{1'b1, 2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2'b01};
    vecs[1] = '{1'b1, 2'b01, 32'h0000_0000, 32'h0000_00FF, 32'h0000_0080, 2'b01};
    vecs[2] = '{1'b1, 2'b10, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 2'b10};
    vecs[3] = '{1'b1, 2'b01, 32'hCAFE_F00D, 32'h0000_0000, 32'h0000_0000, 2'b10};
    vecs[4] = '{1'b0, 2'b01, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'b10};
    vecs[5] = '{1'b1, 2'b00, 32'hA5A5_5A5A, 32'h0000_0000, 32'h0000_0000, 2'b00};
    vecs[6] = '{1'b1, 2'b11, 32'h0F0F_F0F0, 32'h0000_0000, 32'h0000_0000, 2'b00};
    vecs[7] = '{1'b1, 2'b11, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 2'b11};
    vecs[8] = '{1'b1, 2'b10, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000, 2'b11};

    do_reset(2, 1'b1);
    check("rst_valid", {63'd0, o_data_valid}, 64'd0);
    check("rst_data", {32'd0, o_data}, 64'd0);
    check("rst_hdr", {62'd0, o_hdr}, 64'd0);

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v, 1'b0, vecs[i].h, vecs[i].d, 1'b0);
      check($sformatf("vec%0d_hdr", i), {62'd0, o_hdr}, {62'd0, vecs[i].exp_hdr});
      check($sformatf("vec%0d_data", i), {32'd0, o_data & vecs[i].mask},
            {32'd0, vecs[i].exp_data});
    end

    // pause with valid input held: output frozen, then the held word appears once
    step(1'b1, 1'b0, 2'b10, 32'h1111_2222, 1'b0);
    step(1'b1, 1'b1, 2'b01, 32'h3333_4444, 1'b0);
    step(1'b1, 1'b1, 2'b01, 32'h3333_4444, 1'b0);
    step(1'b1, 1'b0, 2'b01, 32'h3333_4444, 1'b0);
    step(1'b0, 1'b1, 2'b01, 32'h0000_0000, 1'b0);
    step(1'b0, 1'b0, 2'b01, 32'h0000_0000, 1'b0);
    check("pause_nodup", {32'd0, exp_q.size()}, 64'd0);

    // reset mid-block
    step(1'b1, 1'b0, 2'b10, 32'h5555_AAAA, 1'b0);
    do_reset(1, 1'b1);
    check("midrst_valid", {63'd0, o_data_valid}, 64'd0);
    step(1'b1, 1'b0, 2'b01, 32'h0000_0000, 1'b0);
    check("midrst_hdr", {62'd0, o_hdr}, {62'd0, 2'b01});
    check("midrst_w0", {32'd0, o_data}, 64'd0);
    step(1'b1, 1'b0, 2'b10, 32'h0000_0000, 1'b0);
    check("midrst_w1", {32'd0, o_data & 32'h0000_00FF}, {32'd0, 32'h0000_0080});
    check("midrst_hdr1", {62'd0, o_hdr}, {62'd0, 2'b01});

`ifdef TX_SCRAMBLER_BYPASS_EN
    step(1'b1, 1'b0, 2'b01, 32'hDEAD_BEEF, 1'b1);
    check("bypass_data", {32'd0, o_data}, {32'd0, 32'hDEAD_BEEF});
    step(1'b1, 1'b0, 2'b10, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 1'b0, 2'b10, 32'h0BAD_F00D, 1'b0);
    step(1'b1, 1'b0, 2'b11, 32'h7654_3210, 1'b0);
`endif

    // random round trip with pauses and gaps
    for (int b = 0; b < 1000; b++) begin
      bh = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      for (int k = 0; k < 2; k++) begin
        w = $urandom();
        while ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) step(1'b0, 1'b0, 2'b00, $urandom(), 1'b0);
          else step($urandom_range(0, 1) == 1, 1'b1, bh, w, 1'b0);
        end
        step(1'b1, 1'b0, (k == 0) ? bh : 2'($urandom_range(0, 3)), w, 1'b0);
      end
    end
    check("sb_drained", {32'd0, exp_q.size()}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
